// File: rtl/lab4_branch_branch_update_sched.sv
// Port scheduler sharing the gshare predictor's single PC/update port between lookups and buffered resolutions.
// Optional macro LAB4_BRANCH_UPDATE_SCHED_BYPASS_EN: zero-latency update when the FIFO is empty and the port is free.
module lab4_branch_branch_update_sched #(
  parameter int DEPTH     = 4,
  parameter int MAX_DEFER = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     lkp_val,
  input  logic [31:0]              lkp_pc,
  output logic                     lkp_rdy,
  output logic                     lkp_pred,
  input  logic                     res_val,
  input  logic [31:0]              res_pc,
  input  logic                     res_taken,
  output logic                     res_rdy,
  output logic [31:0]              bp_pc,
  output logic                     bp_update_en,
  output logic                     bp_update_val,
  input  logic                     bp_prediction,
  output logic [$clog2(DEPTH):0]   pending
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(MAX_DEFER + 1);

  typedef enum logic {NORMAL, FORCE} state_t;

  state_t             state, state_nxt;
  logic [31:0]        fifo_pc [DEPTH];
  logic [DEPTH-1:0]   fifo_tk;
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count, count_nxt;
  logic [DW-1:0]      defer, defer_nxt;
  logic               push, pop, lkp_issue, bypass;

  assign res_rdy = (count != CW'(DEPTH));
  assign pending = count;

  // Port arbitration: lookups win in NORMAL, otherwise the FIFO head drains.
  always_comb begin
    lkp_rdy       = (state == NORMAL);
    lkp_pred      = 1'b0;
    bp_pc         = '0;
    bp_update_en  = 1'b0;
    bp_update_val = 1'b0;
    pop           = 1'b0;
    lkp_issue     = 1'b0;
    bypass        = 1'b0;
    if (state == NORMAL && lkp_val) begin
      lkp_issue = 1'b1;
      bp_pc     = lkp_pc;
      lkp_pred  = bp_prediction;
    end else if (count != '0) begin
      pop           = 1'b1;
      bp_pc         = fifo_pc[rd_ptr];
      bp_update_en  = 1'b1;
      bp_update_val = fifo_tk[rd_ptr];
    end
`ifdef LAB4_BRANCH_UPDATE_SCHED_BYPASS_EN
    else if (state == NORMAL && res_val) begin
      bypass        = 1'b1;
      bp_pc         = res_pc;
      bp_update_en  = 1'b1;
      bp_update_val = res_taken;
    end
`endif
  end

  assign push      = res_val && res_rdy && !bypass;
  assign count_nxt = count + CW'(push) - CW'(pop);

  // Defer counts only cycles where a waiting update lost the port to a lookup.
  always_comb begin
    defer_nxt = defer;
    if (pop || count == '0)
      defer_nxt = '0;
    else if (lkp_issue)
      defer_nxt = defer + DW'(1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      NORMAL: if (defer_nxt == DW'(MAX_DEFER) || count_nxt == CW'(DEPTH)) state_nxt = FORCE;
      FORCE:  if (count_nxt == '0) state_nxt = NORMAL;
      default: state_nxt = NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= NORMAL;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      defer  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      defer <= defer_nxt;
      state <= state_nxt;
    end
  end

  // Entry storage needs no reset: validity is tracked by pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr] <= res_pc;
      fifo_tk[wr_ptr] <= res_taken;
    end
  end
endmodule

// File: tb/tb_lab4_branch_branch_update_sched.sv
// Bench for the predictor port scheduler: vector table, directed corner sequences and a queue-based random model.
module tb_lab4_branch_branch_update_sched;
  localparam int DEPTH     = 4;
  localparam int MAX_DEFER = 8;
`ifdef LAB4_BRANCH_UPDATE_SCHED_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b0;
  logic        lkp_val = 1'b0, res_val = 1'b0, res_taken = 1'b0;
  logic [31:0] lkp_pc = '0, res_pc = '0;
  logic        lkp_rdy, lkp_pred, res_rdy, bp_update_en, bp_update_val, bp_prediction;
  logic [31:0] bp_pc;
  logic [2:0]  pending;

  always #5 clk = ~clk;

  function automatic logic pf(logic [31:0] p);
    return ^p[9:2];
  endfunction

  // Stand-in predictor: prediction is a pure function of the presented PC.
  assign bp_prediction = pf(bp_pc);

  lab4_branch_branch_update_sched #(.DEPTH(DEPTH), .MAX_DEFER(MAX_DEFER)) dut (
    .clk(clk), .reset(reset),
    .lkp_val(lkp_val), .lkp_pc(lkp_pc), .lkp_rdy(lkp_rdy), .lkp_pred(lkp_pred),
    .res_val(res_val), .res_pc(res_pc), .res_taken(res_taken), .res_rdy(res_rdy),
    .bp_pc(bp_pc), .bp_update_en(bp_update_en), .bp_update_val(bp_update_val),
    .bp_prediction(bp_prediction), .pending(pending)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending resolutions as a queue, a force flag and a defer tally.
  typedef struct { logic [31:0] pc; logic taken; } ent_t;
  ent_t mq[$];
  bit   m_frc;
  int   m_defer;
  logic e_lkp_rdy, e_pred, e_en, e_val, e_res_rdy, e_pop, e_push, e_lkp, e_byp;
  logic [31:0] e_pc;

  task automatic model_clear();
    mq.delete();
    m_frc   = 0;
    m_defer = 0;
  endtask

  task automatic model_comb();
    int n = mq.size();
    e_res_rdy = (n != DEPTH);
    e_lkp_rdy = !m_frc;
    e_pred = 0; e_pc = '0; e_en = 0; e_val = 0; e_pop = 0; e_lkp = 0; e_byp = 0;
    if (!m_frc && lkp_val) begin
      e_lkp = 1; e_pc = lkp_pc; e_pred = pf(lkp_pc);
    end else if (n > 0) begin
      e_pop = 1; e_pc = mq[0].pc; e_en = 1; e_val = mq[0].taken;
    end else if (BYP && res_val) begin
      e_byp = 1; e_pc = res_pc; e_en = 1; e_val = res_taken;
    end
    e_push = res_val && e_res_rdy && !e_byp;
  endtask

  task automatic model_edge();
    int n = mq.size();
    ent_t e;
    if (e_pop) void'(mq.pop_front());
    if (e_push) begin
      e.pc = res_pc; e.taken = res_taken;
      mq.push_back(e);
    end
    if (e_pop || n == 0) m_defer = 0;
    else if (e_lkp) m_defer = m_defer + 1;
    if (!m_frc) begin
      if (m_defer == MAX_DEFER || mq.size() == DEPTH) m_frc = 1;
    end else if (mq.size() == 0) begin
      m_frc = 0;
    end
  endtask

  // Inputs are already applied at the falling edge; check, then advance model and DUT together.
  task automatic step(string tag);
    #1;
    model_comb();
    chk({tag, ".lkp_rdy"}, 32'(lkp_rdy), 32'(e_lkp_rdy));
    chk({tag, ".lkp_pred"}, 32'(lkp_pred & lkp_rdy & lkp_val), 32'(e_pred));
    chk({tag, ".bp_pc"}, bp_pc, e_pc);
    chk({tag, ".upd_en"}, 32'(bp_update_en), 32'(e_en));
    chk({tag, ".upd_val"}, 32'(bp_update_val), 32'(e_val));
    chk({tag, ".res_rdy"}, 32'(res_rdy), 32'(e_res_rdy));
    chk({tag, ".pending"}, 32'(pending), 32'(mq.size()));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(logic lv, logic [31:0] lpc, logic rv, logic [31:0] rpc, logic rt);
    lkp_val = lv; lkp_pc = lpc; res_val = rv; res_pc = rpc; res_taken = rt;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    chk("rst.pending", 32'(pending), 0);
    chk("rst.upd_en", 32'(bp_update_en), 0);
    chk("rst.lkp_rdy", 32'(lkp_rdy), 1);
    chk("rst.res_rdy", 32'(res_rdy), 1);
    chk("rst.bp_pc", bp_pc, 0);
    @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  typedef struct {
    logic lv; logic [31:0] lpc; logic rv; logic [31:0] rpc; logic rt;
    logic x_lrdy; logic x_pred; logic x_en; logic [31:0] x_pc; logic x_val; logic [2:0] x_pend; logic x_rrdy;
  } vec_t;
  vec_t tv[11];

  initial begin
    // Held-lookup starvation case: 8 deferred cycles, then one forced drain.
    tv[0] = '{1, 32'h40, 1, 32'h100, 1, 1, pf(32'h40), 0, 32'h40, 0, 0, 1};
    for (int i = 1; i <= 8; i++)
      tv[i] = '{1, 32'h40 + 32'(4*i), 0, 0, 0, 1, pf(32'h40 + 32'(4*i)), 0, 32'h40 + 32'(4*i), 0, 1, 1};
    tv[9]  = '{1, 32'h80, 0, 0, 0, 0, 0, 1, 32'h100, 1, 1, 1};
    tv[10] = '{1, 32'h84, 0, 0, 0, 1, pf(32'h84), 0, 32'h84, 0, 0, 1};

    #2;
    chk("init.pending", 32'(pending), 0);
    chk("init.upd_en", 32'(bp_update_en), 0);
    chk("init.upd_val", 32'(bp_update_val), 0);
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    step("idle");
    step("idle");

    for (int i = 0; i < 11; i++) begin
      drive(tv[i].lv, tv[i].lpc, tv[i].rv, tv[i].rpc, tv[i].rt);
      #1;
      chk($sformatf("tv%0d.lkp_rdy", i), 32'(lkp_rdy), 32'(tv[i].x_lrdy));
      chk($sformatf("tv%0d.lkp_pred", i), 32'(lkp_pred), 32'(tv[i].x_pred));
      chk($sformatf("tv%0d.upd_en", i), 32'(bp_update_en), 32'(tv[i].x_en));
      chk($sformatf("tv%0d.bp_pc", i), bp_pc, tv[i].x_pc);
      chk($sformatf("tv%0d.upd_val", i), 32'(bp_update_val), 32'(tv[i].x_val));
      chk($sformatf("tv%0d.pending", i), 32'(pending), 32'(tv[i].x_pend));
      chk($sformatf("tv%0d.res_rdy", i), 32'(res_rdy), 32'(tv[i].x_rrdy));
      @(negedge clk);
    end

    // Single resolution with an idle lookup port.
    do_reset();
    drive(0, 0, 1, 32'h100, 1);
    step("single");
    drive(0, 0, 0, 0, 0);
    step("single");
    step("single");

    // Fill to DEPTH under continuous lookups, then forced in-order drain.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h1000 + 32'(i*4), 1, 32'h200 + 32'(i*4), 1'(i));
      step("fill");
    end
    drive(1, 32'h2000, 0, 0, 0);
    for (int i = 0; i < 6; i++) step("fill");

    // Push and pop together at count 2 long enough to wrap the pointers.
    do_reset();
    drive(1, 32'h40, 1, 32'h300, 1); step("wrap");
    drive(1, 32'h44, 1, 32'h304, 0); step("wrap");
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 1, 32'h400 + 32'(i*4), 1'(i & 1));
      step("wrap");
      chk("wrap.hold2", 32'(pending), 2);
    end
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("wrap");

    // Asynchronous reset while FORCE holds three entries.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h60, 1, 32'h500 + 32'(i*4), 1);
      step("frst");
    end
    drive(1, 32'h64, 0, 0, 0);
    step("frst");
    chk("frst.pend3", 32'(pending), 3);
    chk("frst.inforce", 32'(lkp_rdy), 0);
    drive(0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    chk("frst.pending", 32'(pending), 0);
    chk("frst.upd_en", 32'(bp_update_en), 0);
    chk("frst.lkp_rdy", 32'(lkp_rdy), 1);
    chk("frst.bp_pc", bp_pc, 0);
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    for (int i = 0; i < 4; i++) step("post");

    // Random traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 9) < 6), $urandom & 32'hFFFF_FFFC,
            1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lab4_branch_branch_update_sched.md
# lab4_branch_branch_update_sched

Port scheduler for the single-ported gshare branch predictor (`lab4_branch_BranchGshare`). It shares the predictor's one PC/update port between fetch-stage prediction lookups and execute-stage branch resolutions. Resolutions are buffered in a small FIFO and drained into the predictor in idle lookup cycles. A defer counter and a forced-drain state prevent starvation of updates.

## Interface
- `DEPTH`, 4: pending-resolution FIFO entries; power of two, ≥2.
- `MAX_DEFER`, 8: maximum consecutive cycles a non-empty FIFO may lose arbitration to lookups; ≥1.

- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `lkp_val`  in  1  fetch requests a prediction.
- `lkp_pc`  in  32  PC of the lookup.
- `lkp_rdy`  out  1  lookup granted this cycle.
- `lkp_pred`  out  1  prediction; valid when `lkp_val && lkp_rdy`.
- `res_val`  in  1  execute presents a resolved branch.
- `res_pc`  in  32  PC of the resolved branch.
- `res_taken`  in  1  resolved direction.
- `res_rdy`  out  1  resolution accepted this cycle.
- `bp_pc`  out  32  predictor `PC`.
- `bp_update_en`  out  1  predictor `update_en`.
- `bp_update_val`  out  1  predictor `update_val`.
- `bp_prediction`  in  1  predictor `prediction`.
- `pending`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- FIFO entry = {pc[31:0], taken}. Push on `res_val && res_rdy`; pop when the head is issued to the predictor.
- `res_rdy = (count != DEPTH)`. It depends on registered count only, not on a same-cycle pop.
- FSM states: NORMAL, FORCE.
- NORMAL:
  - `lkp_rdy = 1`.
  - If `lkp_val`, a lookup is issued: `bp_pc = lkp_pc`, `bp_update_en = 0`, `lkp_pred = bp_prediction`.
  - Else, if count > 0, the head is issued: `bp_pc = head.pc`, `bp_update_en = 1`, `bp_update_val = head.taken`, pop.
  - Else the port is idle: `bp_pc = 0`, `bp_update_en = 0`.
- Defer counter (width $clog2(MAX_DEFER+1)):
  - Increments in NORMAL when count > 0 and a lookup is issued.
  - Clears on any update issue, and whenever count == 0.
- NORMAL → FORCE at posedge when the next-state defer counter == MAX_DEFER, or the next-state count == DEPTH.
- FORCE:
  - `lkp_rdy = 0`; `lkp_pred = 0`.
  - The head is issued every cycle, one pop per cycle.
  - Resolutions are still accepted while `res_rdy`.
- FORCE → NORMAL at posedge when the next-state count == 0. The defer counter clears.
- Simultaneous push and pop in one cycle: count unchanged; pointers both advance. Pointers wrap modulo DEPTH.
- Updates reach the predictor in strict arrival order. Lookups never reorder.
- `bp_update_val = 0` whenever `bp_update_en = 0`.

## Timing
- Reset (`reset` low, asynchronous):
  - FIFO emptied; pointers, count and defer counter = 0; state = NORMAL.
  - Outputs: `pending = 0`, `res_rdy = 1`, `lkp_rdy = 1`, `bp_update_en = 0`, `bp_update_val = 0`, `bp_pc = 0` (with `lkp_val` low).
- Reset mid-operation discards all pending entries; no update is issued for them.
- Lookup latency is 0 cycles: `lkp_pred` is combinational through the predictor. `lkp_rdy` never depends on `lkp_val`.
- Resolution-to-predictor latency: minimum 1 cycle (push at edge N, issue in cycle N+1). Worst case MAX_DEFER+DEPTH cycles.
- Throughput: one predictor operation per cycle, either a lookup or an update.

## Configuration
- `LAB4_BRANCH_UPDATE_SCHED_BYPASS_EN` defined: in NORMAL, when count == 0, `res_val` = 1 and `lkp_val` = 0:
  - The resolution is issued to the predictor in the same cycle (`bp_pc = res_pc`, `bp_update_val = res_taken`, `bp_update_en = 1`).
  - It is not enqueued; `res_rdy = 1`. Latency is 0 cycles.
- Undefined: every resolution passes through the FIFO (minimum 1-cycle latency).

## Test plan
- Reset low, then high with no activity → `pending = 0`, `res_rdy = 1`, `lkp_rdy = 1`, `bp_update_en = 0`, `bp_pc = 0`.
- One resolution (pc 0x100, taken 1) with `lkp_val = 0`:
  - Without macro: cycle N+1 shows `bp_update_en = 1`, `bp_pc = 0x100`, `bp_update_val = 1`; `pending` goes 1 → 0.
  - With macro: the update is issued in cycle N; `pending` stays 0.
- `lkp_val` held high, one resolution pushed:
  - Lookups are granted for 8 cycles; then FORCE with `lkp_rdy = 0` for 1 cycle while the update drains.
  - The FSM then returns to NORMAL.
- `lkp_val` held high, 4 resolutions pushed back-to-back (DEPTH = 4):
  - `res_rdy = 0` after 4 pushes; FORCE drains 4 updates in push order over 4 cycles; `lkp_rdy = 0` throughout.
- Push and drain in the same cycle at count 2: count stays 2, order is preserved, and pointers wrap past entry 3 correctly.
- Assert `reset` low while `pending = 3` in FORCE:
  - Immediately `pending = 0`, `bp_update_en = 0`, state NORMAL.
  - No stale update is issued after release.
